// File: rtl/obi_sram_pkg.sv
// obi_sram_pkg: shared OBI request/response types, response metadata and error constant
// for obi_multiport_sram (optional macro OBI_SRAM_RDATA_REG_EN is handled in the top).
package obi_sram_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;
    localparam int          PORT_W    = 3;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic              is_write;
        logic              is_err;
    } resp_meta_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: combinational round-robin arbiter with a rotating priority pointer
// that moves past the winner on every granted cycle.
module obi_rr_arbiter
    import obi_sram_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = idx_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_next;
    logic          w_any;

    // Scan offsets from the far end so the requester closest to the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[IW'((int'(r_ptr) + k) % N)]) begin
                w_any = 1'b1;
                w_idx = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign gnt_o  = (w_any && adv_i) ? (N'(1) << w_idx) : '0;
    assign idx_o  = w_idx;
    assign w_next = (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_any && adv_i) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/obi_multiport_sram.sv
// obi_multiport_sram: NPORTS OBI initiators round-robin arbitrated onto one word SRAM.
// Define OBI_SRAM_RDATA_REG_EN to add an output register (rvalid 2 cycles after gnt).
module obi_multiport_sram
    import obi_sram_pkg::*;
#(
    parameter int          NPORTS    = 3,
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int IW = idx_width(NPORTS),
    localparam int AW = $clog2(NUM_WORDS)
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  req_i  [NPORTS],
    output obi_resp_t resp_o [NPORTS]
);

    logic [NPORTS-1:0] w_req;
    logic [NPORTS-1:0] w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_fire;
    logic              w_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_off;
    logic              w_in;
    logic [AW-1:0]     w_widx;
    logic [31:0]       r_mem [NUM_WORDS];
    logic [31:0]       r_rd;
    logic              r_v1;
    resp_meta_t        r_m1;
    logic [31:0]       w_d1;
    logic              w_ov;
    resp_meta_t        w_om;
    logic [31:0]       w_od;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) w_req[p] = req_i[p].req;
    end

    // Grants are suppressed while in reset by tying the advance enable to rst_ni.
    obi_rr_arbiter #(.N(NPORTS)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (w_req),
        .adv_i  (rst_ni),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx)
    );

    assign w_fire  = |w_gnt;
    assign w_we    = req_i[w_idx].we;
    assign w_be    = req_i[w_idx].be;
    assign w_wdata = req_i[w_idx].wdata;
    assign w_off   = req_i[w_idx].addr - BASE_ADDR;
    assign w_in    = w_off < 32'(4 * NUM_WORDS);
    assign w_widx  = w_off[AW+1:2];

    always_ff @(posedge clk_i) begin
        if (w_fire && w_in) begin
            if (w_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end else begin
                r_rd <= r_mem[w_widx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1 <= 1'b0;
            r_m1 <= '0;
        end else begin
            r_v1 <= w_fire;
            if (w_fire) r_m1 <= '{port: PORT_W'(w_idx), is_write: w_we, is_err: !w_in};
        end
    end

    assign w_d1 = (!r_v1 || r_m1.is_write) ? '0 : r_m1.is_err ? ERR_RDATA : r_rd;

`ifdef OBI_SRAM_RDATA_REG_EN
    logic       r_v2;
    resp_meta_t r_m2;
    logic [31:0] r_d2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v2 <= 1'b0;
            r_m2 <= '0;
            r_d2 <= '0;
        end else begin
            r_v2 <= r_v1;
            r_m2 <= r_m1;
            r_d2 <= w_d1;
        end
    end

    assign w_ov = r_v2;
    assign w_om = r_m2;
    assign w_od = r_d2;
`else
    assign w_ov = r_v1;
    assign w_om = r_m1;
    assign w_od = w_d1;
`endif

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            resp_o[p].gnt    = w_gnt[p];
            resp_o[p].rvalid = w_ov && (w_om.port == PORT_W'(p));
            resp_o[p].rdata  = (w_ov && (w_om.port == PORT_W'(p))) ? w_od : '0;
        end
    end

endmodule

// File: tb/tb_obi_multiport_sram.sv
// tb_obi_multiport_sram: table-driven stimulus with a response scoreboard for obi_multiport_sram.
module tb_obi_multiport_sram;
    import obi_sram_pkg::*;

`ifdef OBI_SRAM_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [2:0]  req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  exp_gnt;
    } vec_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] rdata;
    } exp_t;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b0;
    obi_req_t  req  [3];
    obi_resp_t resp [3];

    vec_t        tbl [$];
    exp_t        sb  [$];
    logic [31:0] mdl [int];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    obi_multiport_sram #(.NPORTS(3), .NUM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req),
        .resp_o (resp)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] r, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d, input logic [2:0] g);
        tbl.push_back('{r, w, b, a, d, g});
    endfunction

    function automatic logic [2:0] gnt_vec();
        return {resp[2].gnt, resp[1].gnt, resp[0].gnt};
    endfunction

    task automatic drive(input vec_t v);
        for (int p = 0; p < 3; p++) begin
            req[p].req   = v.req[p];
            req[p].we    = v.we;
            req[p].be    = v.be;
            req[p].addr  = v.addr + 32'(4 * p);
            req[p].wdata = v.wdata + 32'(p);
        end
    endtask

    task automatic check_resp();
        logic [2:0]  ev = '0;
        logic [31:0] ed [3] = '{default: '0};
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e = sb.pop_front();
            chk("resp_due", 32'(e.due), 32'(cyc));
            ev[e.port] = 1'b1;
            ed[e.port] = e.rdata;
        end
        chk("rvalid", {29'b0, resp[2].rvalid, resp[1].rvalid, resp[0].rvalid}, {29'b0, ev});
        for (int p = 0; p < 3; p++) chk($sformatf("rdata%0d", p), resp[p].rdata, ed[p]);
    endtask

    // Expected response for the port the bench itself decided should win.
    task automatic model(input vec_t v);
        int          g = -1;
        logic [31:0] a, d, old;
        for (int p = 2; p >= 0; p--) if (v.exp_gnt[p]) g = p;
        if (g < 0) return;
        a = v.addr + 32'(4 * g);
        d = v.wdata + 32'(g);
        if (v.we) begin
            if (a < 32'h1000) begin
                old = mdl.exists(int'(a[11:2])) ? mdl[int'(a[11:2])] : 32'h0;
                for (int b = 0; b < 4; b++) if (v.be[b]) old[8*b +: 8] = d[8*b +: 8];
                mdl[int'(a[11:2])] = old;
            end
            sb.push_back('{cyc + LAT, g, 32'h0});
        end else begin
            sb.push_back('{cyc + LAT, g, (a < 32'h1000) ? mdl[int'(a[11:2])] : 32'hBADA_CCE5});
        end
    endtask

    task automatic step(input vec_t v);
        check_resp();
        drive(v);
        #1;
        chk("gnt", {29'b0, gnt_vec()}, {29'b0, v.exp_gnt});
        model(v);
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        vec_t v;
        v = '{3'b111, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000};
        drive(v);
        repeat (2) @(negedge clk_i);
        chk("rst_gnt", {29'b0, gnt_vec()}, 32'h0);
        chk("rst_rvalid", {29'b0, resp[2].rvalid, resp[1].rvalid, resp[0].rvalid}, 32'h0);
        chk("rst_rdata", resp[0].rdata | resp[1].rdata | resp[2].rdata, 32'h0);
        v.req = 3'b000;
        drive(v);
        rst_ni = 1'b1;

        add(3'b001, 1, 4'hF, 32'h10,   32'hDEADBEEF, 3'b001);
        add(3'b001, 0, 4'h0, 32'h10,   32'h0,        3'b001);
        add(3'b001, 1, 4'hF, 32'h20,   32'h11223344, 3'b001);
        add(3'b001, 1, 4'h5, 32'h20,   32'hAABBCCDD, 3'b001);
        add(3'b001, 0, 4'h0, 32'h20,   32'h0,        3'b001);
        add(3'b001, 1, 4'h0, 32'h20,   32'hFFFFFFFF, 3'b001);
        add(3'b001, 0, 4'h0, 32'h20,   32'h0,        3'b001);
        add(3'b000, 0, 4'h0, 32'h0,    32'h0,        3'b000);
        add(3'b001, 1, 4'hF, 32'h0,    32'h12345678, 3'b001);
        add(3'b001, 0, 4'h0, 32'h1000, 32'h0,        3'b001);
        add(3'b001, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 3'b001);
        add(3'b001, 0, 4'h0, 32'h0,    32'h0,        3'b001);
        add(3'b101, 1, 4'hF, 32'h40,   32'hA5A50000, 3'b100);
        add(3'b101, 1, 4'hF, 32'h40,   32'hA5A50000, 3'b001);
        add(3'b010, 1, 4'hF, 32'h40,   32'hA5A50000, 3'b010);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b100);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b001);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b010);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b100);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b001);
        add(3'b111, 0, 4'h0, 32'h40,   32'h0,        3'b010);
        add(3'b000, 0, 4'h0, 32'h0,    32'h0,        3'b000);
        add(3'b000, 0, 4'h0, 32'h0,    32'h0,        3'b000);
        foreach (tbl[i]) step(tbl[i]);

        // Reset right after a read grant: the pending response must vanish.
        check_resp();
        v = '{3'b001, 1'b0, 4'h0, 32'h10, 32'h0, 3'b001};
        drive(v);
        #1;
        chk("pre_rst_gnt", {29'b0, gnt_vec()}, 32'b001);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        cyc++;
        repeat (3) begin
            @(negedge clk_i);
            check_resp();
            chk("in_rst_gnt", {29'b0, gnt_vec()}, 32'h0);
            @(posedge clk_i);
            cyc++;
        end
        @(negedge clk_i);
        v.req = 3'b000;
        drive(v);
        rst_ni = 1'b1;
        step('{3'b111, 1'b0, 4'h0, 32'h40, 32'h0, 3'b001});
        step('{3'b111, 1'b0, 4'h0, 32'h40, 32'h0, 3'b010});
        step('{3'b111, 1'b0, 4'h0, 32'h40, 32'h0, 3'b100});
        repeat (3) step('{3'b000, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000});
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
